stream_mux_n: RTL and testbench

//  Parametrised N:1 registered multiplexer with valid/ready handshake; next generation of the 2:1 gate mux.

---
 rtl/stream_mux_n_pkg.sv | 17 +
 rtl/stream_mux_n_rr_arbiter.sv | 66 ++++++
 rtl/stream_mux_n.sv | 115 +++++++++++
 tb/tb_stream_mux_n.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_n_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_n_pkg
// Shared constants and helpers for the stream_mux_n block.
//   MODE_SEL : channel chosen by the external sel port
//   MODE_RR  : channel chosen by the internal round-robin arbiter
//   wrap_inc : index + 1 modulo n (pointer advance for the arbiter)
// -----------------------------------------------------------------------------
package stream_mux_n_pkg;

    localparam int unsigned MODE_SEL = 0;
    localparam int unsigned MODE_RR  = 1;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_mux_n_rr_arbiter
// Round-robin arbiter: grants the first requester found searching from the
// priority pointer upwards with wrap-around. The pointer moves to one past the
// granted index whenever the grant is consumed, so every persistent requester
// is served within NUM_IN grants.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (pointer -> 0)
//   req_i      in   NUM_IN request vector
//   advance_i  in   current grant was consumed this cycle
//   grant_o    out  one-hot grant (zero when no request)
//   idx_o      out  binary index of the granted requester
// -----------------------------------------------------------------------------
module stream_mux_n_rr_arbiter
    import stream_mux_n_pkg::*;
#(
    parameter  int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] req_i,
    input  logic              advance_i,
    output logic [NUM_IN-1:0] grant_o,
    output logic [SEL_W-1:0]  idx_o
);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    int unsigned      cand;
    logic             found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            cand = {{(32 - SEL_W){1'b0}}, ptr_q} + k;
            if (cand >= NUM_IN) begin
                cand = cand - NUM_IN;
            end
            if (!found && req_i[cand[SEL_W-1:0]]) begin
                found                     = 1'b1;
                grant_o[cand[SEL_W-1:0]]  = 1'b1;
                idx_o                     = cand[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = SEL_W'(wrap_inc({{(32 - SEL_W){1'b0}}, idx_o}, NUM_IN));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// -----------------------------------------------------------------------------
// stream_mux_n
// N:1 registered stream multiplexer with valid/ready handshake. One source is
// picked per cycle (external sel, or round-robin over valid inputs), its word
// is registered into a single output stage. A pop and a refill may happen on
// the same edge, giving one word per clock.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   in_data    in   NUM_IN*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   per-channel valid
//   in_ready   out  per-channel accept (at most one bit set)
//   sel        in   channel select, MODE_SEL only
//   out_data   out  registered selected word
//   out_valid  out  out_data holds an untaken word
//   out_ready  in   downstream accepts out_data
//   out_src    out  channel that produced out_data
// -----------------------------------------------------------------------------
module stream_mux_n
    import stream_mux_n_pkg::*;
#(
    parameter  int unsigned WIDTH  = 32,
    parameter  int unsigned NUM_IN = 4,
    parameter  int unsigned MODE   = MODE_SEL,
    localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN*WIDTH-1:0]  in_data,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_src
);

    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              free;
    logic              xfer;
    logic [WIDTH-1:0]  mux_data;

    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_src_q, out_src_d;
    logic              out_valid_q, out_valid_d;

    // Slot is free when empty or being drained this cycle.
    assign free     = ~out_valid_q | out_ready;
    // Gating with rst_n keeps in_ready low while reset is held.
    assign in_ready = rst_n ? (grant & {NUM_IN{free}}) : '0;
    assign xfer     = |(in_valid & in_ready);

    if (MODE == MODE_RR) begin : g_rr
        stream_mux_n_rr_arbiter #(
            .NUM_IN (NUM_IN)
        ) u_arb (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_i     (in_valid),
            .advance_i (xfer),
            .grant_o   (grant),
            .idx_o     (grant_idx)
        );
    end else begin : g_sel
        // Only the selected channel's valid is looked at; out-of-range sel
        // matches no channel and so grants nothing.
        always_comb begin
            grant = '0;
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                grant[i] = in_valid[i] & (sel == SEL_W'(i));
            end
        end
        assign grant_idx = sel;
    end

    // AND-OR mux driven by the one-hot grant.
    always_comb begin
        mux_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = mux_data;
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_n
// Three instances share one stimulus: select mode with 4 and 3 channels, and
// round-robin with 4 channels. A behavioural model tracks the expected output
// slot of each instance.
// -----------------------------------------------------------------------------
module tb_stream_mux_n;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_valid;
    logic [1:0]     sel;
    logic           out_ready;

    logic [3:0]     rdy_a, rdy_c;
    logic [2:0]     rdy_b;
    logic [W-1:0]   od [3];
    logic           ov [3];
    logic [1:0]     os [3];

    always #5 clk = ~clk;

    stream_mux_n #(.WIDTH(W), .NUM_IN(4), .MODE(0)) u_sel4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_a), .sel(sel), .out_data(od[0]), .out_valid(ov[0]),
        .out_ready(out_ready), .out_src(os[0])
    );

    stream_mux_n #(.WIDTH(W), .NUM_IN(3), .MODE(0)) u_sel3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[3*W-1:0]), .in_valid(in_valid[2:0]),
        .in_ready(rdy_b), .sel(sel), .out_data(od[1]), .out_valid(ov[1]),
        .out_ready(out_ready), .out_src(os[1])
    );

    stream_mux_n #(.WIDTH(W), .NUM_IN(4), .MODE(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_c), .sel(sel), .out_data(od[2]), .out_valid(ov[2]),
        .out_ready(out_ready), .out_src(os[2])
    );

    // Reference model state per instance.
    int          n_of    [3] = '{4, 3, 4};
    int          mode_of [3] = '{0, 0, 1};
    bit          m_v [3];
    logic [31:0] m_d [3];
    int          m_s [3];
    int          m_p [3];

    int checks = 0;
    int errors = 0;
    int rr_took = 0;

    int rr_seq_a [5] = '{0, 1, 2, 3, 0};
    int rr_seq_b [5] = '{0, 2, 3, 0, 2};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel the spec's selection rule picks for instance k, -1 if none.
    function automatic int pick(input int k);
        int c;
        if (mode_of[k] == 0) begin
            if (int'(sel) < n_of[k] && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int o = 0; o < n_of[k]; o++) begin
            c = (m_p[k] + o) % n_of[k];
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_v[k] = 1'b0;
            m_d[k] = '0;
            m_s[k] = 0;
            m_p[k] = 0;
        end
    endtask

    task automatic check_outs(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s[%0d].valid", tag, k), {63'd0, ov[k]}, {63'd0, m_v[k]});
            chk($sformatf("%s[%0d].data", tag, k), {32'd0, od[k]}, {32'd0, m_d[k]});
            chk($sformatf("%s[%0d].src", tag, k), {62'd0, os[k]}, 64'(m_s[k]));
        end
    endtask

    // One clock: check in_ready against the model, clock, update model, check outputs.
    task automatic step(input string tag);
        int         g  [3];
        logic [3:0] er [3];
        #1;
        for (int k = 0; k < 3; k++) begin
            g[k]  = pick(k);
            er[k] = (g[k] >= 0 && (!m_v[k] || out_ready)) ? 4'(1 << g[k]) : 4'd0;
        end
        chk({tag, ".rdy0"}, {60'd0, rdy_a}, {60'd0, er[0]});
        chk({tag, ".rdy1"}, {60'd0, 1'b0, rdy_b}, {60'd0, er[1]});
        chk({tag, ".rdy2"}, {60'd0, rdy_c}, {60'd0, er[2]});
        if (rdy_c != 4'd0) rr_took++;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (er[k] != 4'd0) begin
                m_v[k] = 1'b1;
                m_d[k] = in_data[g[k]*W +: W];
                m_s[k] = g[k];
                m_p[k] = (g[k] + 1) % n_of[k];
            end else if (out_ready) begin
                m_v[k] = 1'b0;
            end
        end
        #1;
        check_outs(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_outs(tag);
        chk({tag, ".rdy0"}, {60'd0, rdy_a}, 64'd0);
        #3 rst_n = 1'b1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < 4; i++) in_data[i*W +: W] = $urandom;
    endtask

    initial begin
        in_data   = '0;
        in_valid  = '0;
        sel       = '0;
        out_ready = 1'b0;
        model_reset();

        // Reset held: outputs zero and no channel accepted even with valids up.
        #2 in_valid = 4'hF;
        #1;
        check_outs("reset");
        chk("reset.rdy0", {60'd0, rdy_a}, 64'd0);
        chk("reset.rdy1", {61'd0, rdy_b}, 64'd0);
        chk("reset.rdy2", {60'd0, rdy_c}, 64'd0);
        #9 rst_n = 1'b1;

        // Directed select: channel 2 of A0+i.
        for (int i = 0; i < 4; i++) in_data[i*W +: W] = 32'hA0 + i;
        sel       = 2'd2;
        out_ready = 1'b1;
        step("sel2");
        chk("sel2.data", {32'd0, od[0]}, 64'hA2);
        chk("sel2.src", {62'd0, os[0]}, 64'd2);

        // sel beyond NUM_IN=3: nothing accepted, slot drains.
        sel = 2'd3;
        step("sel_oor");
        chk("sel_oor.n3_valid", {63'd0, ov[1]}, 64'd0);
        chk("sel_oor.data", {32'd0, od[0]}, 64'hA3);

        // Stall three clocks, then release and refill on the same edge.
        sel       = 2'd1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step("stall");
            chk("stall.hold_data", {32'd0, od[0]}, 64'hA3);
            chk("stall.hold_src", {62'd0, os[0]}, 64'd3);
        end
        out_ready = 1'b1;
        step("release");

        // Reset mid-transfer with words pending.
        async_reset("mid_rst");

        // Round-robin sequence with all channels valid.
        in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            step("rr_all");
            chk("rr_all.src", {62'd0, os[2]}, 64'(rr_seq_a[i]));
        end

        // Channel 1 drops out of the rotation.
        async_reset("rr_rst");
        in_valid = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            step("rr_drop1");
            chk("rr_drop1.src", {62'd0, os[2]}, 64'(rr_seq_b[i]));
        end

        // Back-to-back throughput: 16 words in 16 clocks.
        in_valid = 4'hF;
        rr_took  = 0;
        for (int i = 0; i < 16; i++) begin
            rand_data();
            sel = 2'($urandom);
            step("thru");
            chk("thru.valid", {63'd0, ov[2]}, 64'd1);
        end
        chk("thru.count", 64'(rr_took), 64'd16);

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            rand_data();
            in_valid  = 4'($urandom);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
